// File: rtl/bsg_mesh_router_age_input_buffer_pkg.sv
// Shared types and constants for the age-arbitrated mesh router input buffer.
//  BSG_MESH_AGE_TS_T(w) : macro expanding to a w-bit timestamp vector
//  age_input_els_gp     : buffer depth (fixed at 2)
//  age_count_next()     : occupancy update for one enqueue/dequeue cycle
`ifndef BSG_MESH_AGE_TS_T_MACRO
`define BSG_MESH_AGE_TS_T_MACRO
`define BSG_MESH_AGE_TS_T(ts_width_p) logic [ts_width_p-1:0]
`endif

package bsg_mesh_router_age_input_buffer_pkg;

  localparam int unsigned age_input_els_gp   = 2;
  localparam int unsigned age_ptr_width_gp   = 1;
  localparam int unsigned age_count_width_gp = 2;

  // Occupancy after one cycle; enq and deq together leave it unchanged.
  function automatic logic [age_count_width_gp-1:0] age_count_next(
    input logic [age_count_width_gp-1:0] count,
    input logic                          enq,
    input logic                          deq
  );
    return count + age_count_width_gp'(enq) - age_count_width_gp'(deq);
  endfunction

endpackage

// File: rtl/bsg_mesh_router_age_input_buffer_if.sv
// Handshake bundle between upstream, the input buffer and the router.
//  valid_i/data_i/ts_i/ready_o : upstream enqueue side
//  valid_o/data_o/ts_o/yumi_i  : router dequeue side
//  slave  : the buffer's view;  master : the driver/consumer view
interface bsg_mesh_router_age_input_buffer_if #(
  parameter int width_p    = 8,
  parameter int ts_width_p = 8
);
  logic                  valid_i;
  logic [width_p-1:0]    data_i;
  logic [ts_width_p-1:0] ts_i;
  logic                  ready_o;
  logic                  valid_o;
  logic [width_p-1:0]    data_o;
  logic [ts_width_p-1:0] ts_o;
  logic                  yumi_i;

  modport slave (
    input  valid_i, data_i, ts_i, yumi_i,
    output ready_o, valid_o, data_o, ts_o
  );

  modport master (
    output valid_i, data_i, ts_i, yumi_i,
    input  ready_o, valid_o, data_o, ts_o
  );
endinterface

// File: rtl/bsg_mesh_router_age_input_buffer_ts_counter.sv
// Free-running wrapping cycle counter used to age-stamp injected packets.
//  clk_i   : clock
//  reset_i : asynchronous active-high reset, clears the count to 0
//  count_o : current cycle count, wraps to 0 at 2^width_p
module bsg_age_ts_counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q;
  logic [width_p-1:0] count_d;

  // Natural modulo wrap; downstream comparisons are modulo as well.
  assign count_d = count_q + width_p'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_mesh_router_age_input_buffer.sv
// Per-direction input stage of the age-arbitrated mesh router: a 2-entry FIFO of
// {data, ts}. With stamp_p=1 the ts is the local cycle count at enqueue (P port);
// with stamp_p=0 the arriving ts_i is carried through (link ports).
//  clk_i   : clock
//  reset_i : asynchronous active-high reset (control state only)
//  link    : slave modport -- valid_i/data_i/ts_i/ready_o upstream,
//            valid_o/data_o/ts_o/yumi_i toward the router
module bsg_mesh_router_age_input_buffer
  import bsg_mesh_router_age_input_buffer_pkg::*;
#(
  parameter int width_p    = 8,
  parameter int ts_width_p = 8,
  parameter int stamp_p    = 0,
  parameter int els_p      = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  bsg_mesh_router_age_input_buffer_if.slave  link
);

  typedef `BSG_MESH_AGE_TS_T(ts_width_p) bsg_mesh_age_ts_t;

  if (els_p != int'(age_input_els_gp)) begin : g_bad_els
    $error("bsg_mesh_router_age_input_buffer: els_p must be 2");
  end

  logic [age_count_width_gp-1:0] count_q, count_d;
  logic [age_ptr_width_gp-1:0]   rd_ptr_q, rd_ptr_d;
  logic [age_ptr_width_gp-1:0]   wr_ptr_q, wr_ptr_d;
  logic                          valid_q, valid_d;
  logic                          ready_q, ready_d;

  logic [width_p-1:0]            data_mem_q [age_input_els_gp];
  bsg_mesh_age_ts_t              ts_mem_q   [age_input_els_gp];

  bsg_mesh_age_ts_t              ts_in_c;
  logic                          enq_c;
  logic                          deq_c;

  // Timestamp source: local cycle counter on the injection port, else upstream ts.
  if (stamp_p != 0) begin : g_stamp
    bsg_mesh_age_ts_t cycle_r;
    logic             unused_ts_c;

    bsg_age_ts_counter #(
      .width_p (ts_width_p)
    ) u_ts_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .count_o (cycle_r)
    );

    assign ts_in_c     = cycle_r;
    assign unused_ts_c = ^link.ts_i;
  end else begin : g_pass
    assign ts_in_c = link.ts_i;
  end

  // ready/valid come from registers only, so accept never waits on yumi_i.
  // An illegal yumi_i on an empty buffer is masked so state stays put.
  assign enq_c = link.valid_i & ready_q;
  assign deq_c = link.yumi_i & valid_q;

  // Next control state.
  always_comb begin
    count_d  = age_count_next(count_q, enq_c, deq_c);
    rd_ptr_d = rd_ptr_q ^ age_ptr_width_gp'(deq_c);
    wr_ptr_d = wr_ptr_q ^ age_ptr_width_gp'(enq_c);
    valid_d  = (count_d != '0);
    ready_d  = (count_d != age_count_width_gp'(age_input_els_gp));
  end

  // Control state; reset discards every buffered packet.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  // Payload storage, deliberately not reset; data and ts share one index.
  always_ff @(posedge clk_i) begin
    if (enq_c) begin
      data_mem_q[wr_ptr_q] <= link.data_i;
      ts_mem_q[wr_ptr_q]   <= ts_in_c;
    end
  end

  assign link.valid_o = valid_q;
  assign link.ready_o = ready_q;
  assign link.data_o  = data_mem_q[rd_ptr_q];
  assign link.ts_o    = ts_mem_q[rd_ptr_q];

  // The router must only dequeue a valid head.
  a_yumi_needs_valid : assert property (
    @(posedge clk_i) disable iff (reset_i) !(link.yumi_i && !valid_q)
  ) else $error("yumi_i asserted while valid_o is low");

endmodule

// File: tb/tb_bsg_mesh_router_age_input_buffer.sv
module tb_bsg_mesh_router_age_input_buffer;

  localparam int W  = 8;
  localparam int TW = 4;

  logic clk     = 1'b0;
  logic reset_i = 1'b1;

  always #5 clk = ~clk;

  logic          vin = 1'b0;
  logic          yin = 1'b0;
  logic [W-1:0]  din = '0;
  logic [TW-1:0] tin = '0;

  bsg_mesh_router_age_input_buffer_if #(.width_p(W), .ts_width_p(TW)) if_s ();
  bsg_mesh_router_age_input_buffer_if #(.width_p(W), .ts_width_p(TW)) if_p ();

  assign if_s.valid_i = vin;
  assign if_s.data_i  = din;
  assign if_s.ts_i    = tin;
  assign if_s.yumi_i  = yin;
  assign if_p.valid_i = vin;
  assign if_p.data_i  = din;
  assign if_p.ts_i    = tin;
  assign if_p.yumi_i  = yin;

  bsg_mesh_router_age_input_buffer #(
    .width_p(W), .ts_width_p(TW), .stamp_p(1), .els_p(2)
  ) u_stamp (
    .clk_i(clk), .reset_i(reset_i), .link(if_s)
  );

  bsg_mesh_router_age_input_buffer #(
    .width_p(W), .ts_width_p(TW), .stamp_p(0), .els_p(2)
  ) u_pass (
    .clk_i(clk), .reset_i(reset_i), .link(if_p)
  );

  // Reference model: a plain queue; each entry remembers what both DUTs should emit.
  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] ts_s;
    logic [TW-1:0] ts_p;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("valid_s", 32'(if_s.valid_o), 32'(q.size() != 0));
    chk("valid_p", 32'(if_p.valid_o), 32'(q.size() != 0));
    chk("ready_s", 32'(if_s.ready_o), 32'(q.size() != 2));
    chk("ready_p", 32'(if_p.ready_o), 32'(q.size() != 2));
    if (q.size() != 0) begin
      chk("data_s", 32'(if_s.data_o), 32'(q[0].d));
      chk("data_p", 32'(if_p.data_o), 32'(q[0].d));
      chk("ts_s",   32'(if_s.ts_o),   32'(q[0].ts_s));
      chk("ts_p",   32'(if_p.ts_o),   32'(q[0].ts_p));
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [TW-1:0] t,
                      input logic y);
    bit acc, deq;
    vin = v; din = d; tin = t; yin = y;
    @(posedge clk);
    acc = v && (q.size() != 2);
    deq = y && (q.size() != 0);
    if (deq) void'(q.pop_front());
    if (acc) q.push_back('{d: d, ts_s: TW'(cyc), ts_p: t});
    cyc++;
    @(negedge clk);
    compare_model();
  endtask

  // Mid-cycle async reset; valid_o must drop without waiting for a clock.
  task automatic do_reset();
    #2;
    reset_i = 1'b1;
    vin = 1'b0;
    yin = 1'b0;
    #1;
    chk("rst_async_valid_s", 32'(if_s.valid_o), 32'd0);
    chk("rst_async_valid_p", 32'(if_p.valid_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    q.delete();
    cyc = 0;
    chk("rst_ready_s", 32'(if_s.ready_o), 32'd1);
    chk("rst_valid_s", 32'(if_s.valid_o), 32'd0);
    chk("rst_ready_p", 32'(if_p.ready_o), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    cyc = 0;
    chk("init_valid_s", 32'(if_s.valid_o), 32'd0);
    chk("init_ready_s", 32'(if_s.ready_o), 32'd1);
    chk("init_valid_p", 32'(if_p.valid_o), 32'd0);
    chk("init_ready_p", 32'(if_p.ready_o), 32'd1);

    // Stamping: enqueue on cycles 3 and 17 of a 4-bit counter.
    repeat (3) step(1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b1, 8'h33, 4'h5, 1'b0);
    chk("stamp3_ts_s",  32'(if_s.ts_o),   32'h3);
    chk("stamp3_ts_p",  32'(if_p.ts_o),   32'h5);
    chk("stamp3_data",  32'(if_s.data_o), 32'h33);
    step(1'b0, 8'h00, 4'h0, 1'b1);
    repeat (12) step(1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b1, 8'h44, 4'h9, 1'b0);
    chk("stamp17_ts_s", 32'(if_s.ts_o),   32'h1);
    chk("stamp17_ts_p", 32'(if_p.ts_o),   32'h9);
    step(1'b0, 8'h00, 4'h0, 1'b1);

    // Fill to two, then a refused third push.
    step(1'b1, 8'h11, 4'h5, 1'b0);
    step(1'b1, 8'h22, 4'h9, 1'b0);
    chk("fill_ready",   32'(if_s.ready_o), 32'd0);
    chk("fill_data",    32'(if_p.data_o),  32'h11);
    chk("fill_ts_p",    32'(if_p.ts_o),    32'h5);
    step(1'b1, 8'h55, 4'h3, 1'b0);
    chk("refuse_data",  32'(if_s.data_o),  32'h11);
    chk("refuse_ready", 32'(if_p.ready_o), 32'd0);

    // Full plus dequeue: the push alongside is not taken.
    step(1'b1, 8'h66, 4'h2, 1'b1);
    chk("fulldeq_data",  32'(if_s.data_o),  32'h22);
    chk("fulldeq_ts_p",  32'(if_p.ts_o),    32'h9);
    chk("fulldeq_ready", 32'(if_s.ready_o), 32'd1);

    // Simultaneous enqueue/dequeue at one entry.
    step(1'b1, 8'h77, 4'ha, 1'b1);
    chk("simul_data",  32'(if_p.data_o),  32'h77);
    chk("simul_ready", 32'(if_s.ready_o), 32'd1);
    chk("simul_valid", 32'(if_s.valid_o), 32'd1);
    chk("simul_ts_p",  32'(if_p.ts_o),    32'ha);

    // Reset with two entries held.
    step(1'b1, 8'h88, 4'h1, 1'b0);
    chk("prerst_full", 32'(if_s.ready_o), 32'd0);
    do_reset();

    // Randomized traffic with occasional reset while full.
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 2 && $urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(9) < 6),
             W'($urandom),
             TW'($urandom),
             (q.size() != 0) && ($urandom_range(1) == 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
